// File: rtl/alu_issue_if.sv
// Handshake bundle between the issue/dispatch requesters and the ALU issue
// arbiter, including the decoder-side opcode/enable outputs.
interface alu_issue_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] req_opcode;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [4:0]        dec_opcode;
    logic              dec_enable;
    logic              busy;

    // Requester side: raises requests and opcodes, observes grant/completion.
    modport master (
        output req, req_opcode,
        input  gnt, done, dec_opcode, dec_enable, busy
    );

    // Arbiter side: consumes requests, drives grant and decoder inputs.
    modport arb (
        input  req, req_opcode,
        output gnt, done, dec_opcode, dec_enable, busy
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue controller sharing one opcode decoder among NREQ
// requesters. A winner holds the decoder for 1 or MULTI_LAT cycles (chosen by
// MULTI_MASK per opcode), then receives a one-cycle done pulse.
module alu_issue_arbiter #(
    parameter int          NREQ       = 4,
    parameter int          MULTI_LAT  = 4,
    parameter logic [31:0] MULTI_MASK = 32'hFFFF_0000
) (
    input logic      clk,
    input logic      rst_n,
    alu_issue_if.arb bus
);

    localparam int                IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]        LAT_M1 = 4'(MULTI_LAT - 1);
    localparam logic [NREQ-1:0]   ONE    = NREQ'(1);
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [4:0]        dec_opcode_q, dec_opcode_d;
    logic              dec_enable_q, dec_enable_d;
    logic              busy_q, busy_d;

    logic [4:0]        req_op [NREQ];
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  cand;

    // Split the packed opcode bus into one 5-bit opcode per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op[i] = bus.req_opcode[5*i +: 5];
        end
    end

    // Round-robin search: first asserted request at or after ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found = 1'b0;
        sel   = ptr_q;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed here and registered.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        gnt_d        = '0;
        done_d       = '0;
        dec_opcode_d = '0;
        dec_enable_d = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d      = S_EXEC;
                    win_d        = sel;
                    op_d         = req_op[sel];
                    cnt_d        = MULTI_MASK[req_op[sel]] ? LAT_M1 : 4'd0;
                    gnt_d        = ONE << sel;
                    dec_enable_d = 1'b1;
                    dec_opcode_d = req_op[sel];
                    busy_d       = 1'b1;
                end
            end
            S_EXEC: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ptr_d   = (win_q == LAST) ? '0 : win_q + IDX_W'(1);
                    done_d  = ONE << win_q;
                end else begin
                    cnt_d        = cnt_q - 4'd1;
                    gnt_d        = ONE << win_q;
                    dec_enable_d = 1'b1;
                    dec_opcode_d = op_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all control state and outputs are reset; an in-flight op is simply dropped.
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            dec_opcode_q <= '0;
            dec_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            dec_opcode_q <= dec_opcode_d;
            dec_enable_q <= dec_enable_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.dec_opcode = dec_opcode_q;
    assign bus.dec_enable = dec_enable_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter (NREQ=4, MULTI_LAT=4, opcodes 16..31
// multi-cycle). Inputs change and outputs are sampled 1 time unit after the
// rising edge.
module tb_alu_issue_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_issue_if #(.NREQ(NREQ)) bus ();

    alu_issue_arbiter #(
        .NREQ      (NREQ),
        .MULTI_LAT (4),
        .MULTI_MASK(32'hFFFF_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {gnt, done, dec_opcode, dec_enable, busy}.
    logic [14:0] obs;
    assign obs = {bus.gnt, bus.done, bus.dec_opcode, bus.dec_enable, bus.busy};

    function automatic logic [14:0] ev(input logic [3:0] g, input logic [3:0] d,
                                       input logic [4:0] op, input logic en,
                                       input logic b);
        return {g, d, op, en, b};
    endfunction

    // Hand-derived execution length for this configuration.
    function automatic int lat_of(input logic [4:0] op);
        return (op >= 5'd16) ? 4 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [4:0] op);
        bus.req_opcode[5*r +: 5] = op;
    endtask

    // One complete op for requester r, checking every cycle of its life.
    task automatic run_op(input int r, input logic [4:0] op, input string name);
        logic [3:0]  oh;
        logic [14:0] want;
        int          len;
        oh  = 4'b0001 << r;
        len = lat_of(op);
        set_op(r, op);
        bus.req[r] = 1'b1;
        tick();
        for (int c = 0; c < len; c++) begin
            want = ev(oh, 4'b0, op, 1'b1, 1'b1);
            if (obs !== want) begin
                errors++;
                $display("FAIL %s exec[%0d]: got %b want %b (gnt|done|op|en|busy)", name, c, obs, want);
            end
            checks++;
            tick();
        end
        want = ev(4'b0, oh, 5'd0, 1'b0, 1'b1);
        if (obs !== want) begin
            errors++;
            $display("FAIL %s done: got %b want %b", name, obs, want);
        end
        checks++;
        bus.req[r] = 1'b0;
        tick();
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL %s idle: got %b want %b", name, obs, 15'd0);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req        = '0;
        bus.req_opcode = '0;
        #2;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", obs, 15'd0);
        end
        checks++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", obs, 15'd0);
        end
        checks++;
    endtask

    task automatic test_single();
        run_op(0, 5'd3, "single_op3");
    endtask

    task automatic test_multi();
        run_op(2, 5'd20, "multi_op20");
        run_op(2, 5'd15, "multi_op15");
        run_op(2, 5'd16, "multi_op16");
        run_op(2, 5'd31, "multi_op31");
    endtask

    task automatic test_round_robin();
        int          exp_order [6] = '{0, 1, 2, 3, 0, 1};
        int          n    = 0;
        logic [3:0]  pend = '0;
        logic [3:0]  prev = '0;
        logic [3:0]  want_g;
        // Restart the pointer at 0 with a short reset pulse while idle.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req_opcode = '0;
        bus.req        = 4'b1111;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            tick();
            bus.req = bus.req | pend;
            pend    = '0;
            if (bus.gnt != 4'b0 && prev == 4'b0) begin
                want_g = 4'b0001 << exp_order[n];
                if (bus.gnt !== want_g) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %b want %b", n, bus.gnt, want_g);
                end
                checks++;
                n++;
            end
            if (bus.done != 4'b0) begin
                bus.req = bus.req & ~bus.done;
                pend    = bus.done;
            end
            prev = bus.gnt;
        end
        if (n < 6) begin
            errors++;
            checks++;
            $display("FAIL rr_timeout: got %0d grants want 6", n);
        end
        bus.req = '0;
        for (int w = 0; w < 20 && bus.busy; w++) tick();
        tick();
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL rr_idle: got %b want %b", obs, 15'd0);
        end
        checks++;
    endtask

    // Pointer sits at 2 after the last grant to requester 1.
    task automatic test_subset();
        bus.req_opcode = '0;
        bus.req        = 4'b1010;
        tick();
        if (obs !== ev(4'b1000, 4'b0, 5'd0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL subset_gnt3: got %b want %b", obs, ev(4'b1000, 4'b0, 5'd0, 1'b1, 1'b1));
        end
        checks++;
        tick();
        if (obs !== ev(4'b0, 4'b1000, 5'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL subset_done3: got %b want %b", obs, ev(4'b0, 4'b1000, 5'd0, 1'b0, 1'b1));
        end
        checks++;
        bus.req[3] = 1'b0;
        tick();
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL subset_gap: got %b want %b", obs, 15'd0);
        end
        checks++;
        tick();
        if (obs !== ev(4'b0010, 4'b0, 5'd0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL subset_gnt1: got %b want %b", obs, ev(4'b0010, 4'b0, 5'd0, 1'b1, 1'b1));
        end
        checks++;
        tick();
        if (obs !== ev(4'b0, 4'b0010, 5'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL subset_done1: got %b want %b", obs, ev(4'b0, 4'b0010, 5'd0, 1'b0, 1'b1));
        end
        checks++;
        bus.req[1] = 1'b0;
        tick();
    endtask

    task automatic test_opcode_change();
        logic [14:0] want;
        set_op(1, 5'd18);
        bus.req[1] = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            want = ev(4'b0010, 4'b0, 5'd18, 1'b1, 1'b1);
            if (obs !== want) begin
                errors++;
                $display("FAIL opchg exec[%0d]: got %b want %b", c, obs, want);
            end
            checks++;
            if (c == 1) begin
                set_op(1, 5'd2);
                bus.req[1] = 1'b0;
            end
            tick();
        end
        want = ev(4'b0, 4'b0010, 5'd0, 1'b0, 1'b1);
        if (obs !== want) begin
            errors++;
            $display("FAIL opchg done: got %b want %b", obs, want);
        end
        checks++;
        tick();
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL opchg idle: got %b want %b", obs, 15'd0);
        end
        checks++;
    endtask

    task automatic test_reset_mid_exec();
        logic [14:0] want;
        set_op(2, 5'd20);
        bus.req = 4'b0100;
        tick();
        for (int c = 0; c < 2; c++) begin
            want = ev(4'b0100, 4'b0, 5'd20, 1'b1, 1'b1);
            if (obs !== want) begin
                errors++;
                $display("FAIL rstx exec[%0d]: got %b want %b", c, obs, want);
            end
            checks++;
            if (c == 0) tick();
        end
        rst_n = 1'b0;
        #1;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL rstx async_clear: got %b want %b", obs, 15'd0);
        end
        checks++;
        bus.req_opcode = '0;
        bus.req        = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (obs !== 15'd0) begin
                errors++;
                $display("FAIL rstx no_done[%0d]: got %b want %b", c, obs, 15'd0);
            end
            checks++;
        end
        rst_n = 1'b1;
        tick();
        want = ev(4'b0001, 4'b0, 5'd0, 1'b1, 1'b1);
        if (obs !== want) begin
            errors++;
            $display("FAIL rstx first_gnt: got %b want %b", obs, want);
        end
        checks++;
        tick();
        want = ev(4'b0, 4'b0001, 5'd0, 1'b0, 1'b1);
        if (obs !== want) begin
            errors++;
            $display("FAIL rstx first_done: got %b want %b", obs, want);
        end
        checks++;
        bus.req = '0;
        tick();
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL rstx idle: got %b want %b", obs, 15'd0);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_round_robin();
        test_subset();
        test_opcode_change();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Round-robin issue controller that shares the ALU's opcode decoder among `NREQ` requesters. Each requester raises a request with a 5-bit opcode. The arbiter grants one requester and drives the decoder's `opcode`/`enable` inputs for a per-opcode execution length of 1 or `MULTI_LAT` cycles. It then pulses `done` to the winner. It sits between the issue/dispatch logic and the 5-to-32 decoder feeding the ALU datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MULTI_LAT`, 4: execution cycles for multi-cycle opcodes, 1..16.
- `MULTI_MASK`, 32'hFFFF_0000: bit n set means opcode n is multi-cycle; clear means 1 cycle.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request per requester, level.
- `req_opcode`  in  5*NREQ  packed opcodes; requester i uses bits [5i+4:5i].
- `gnt`  out  NREQ  one-hot grant, high for the whole EXEC phase.
- `done`  out  NREQ  one-hot, one-cycle completion pulse.
- `dec_opcode`  out  5  opcode to the decoder.
- `dec_enable`  out  1  decoder enable.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC, DONE. All outputs are registered and derived from state plus latched registers.
- IDLE
  - If any `req` bit is set at a clock edge: select the winner by round-robin search starting at `ptr`, wrapping NREQ-1 to 0.
  - At that edge: latch the winner index and its `req_opcode` slice. Load `cnt` with L-1, where L = `MULTI_LAT` if `MULTI_MASK[opcode]` is set, else 1. Go to EXEC.
  - No request: stay in IDLE with all outputs 0.
- EXEC
  - `gnt[win]`=1, `dec_enable`=1, `dec_opcode`=latched opcode, `busy`=1.
  - `cnt` decrements each cycle. When `cnt`==0: go to DONE and set `ptr` = (win+1) mod NREQ.
- DONE
  - Lasts exactly one cycle: `done[win]`=1, `gnt`=0, `dec_enable`=0, `busy`=1. Then go to IDLE.
- Handshake rules
  - A requester holds `req` high until it samples `done`. It must drop `req` on the edge that samples `done`, or it re-enters arbitration.
  - `req_opcode` is sampled only at the grant edge. Later changes are ignored.
  - If `req` drops during EXEC, the op still completes and `done` still pulses.
- Arbitration edge cases
  - Requests arriving during EXEC or DONE wait for IDLE.
  - A requester is never granted twice in a row while another requester is asserted, because `ptr` advances past the winner.
- `dec_opcode` is 0 whenever `dec_enable` is 0.
- Reset: while `rst_n`=0, asynchronously force state=IDLE, `ptr`=0, `cnt`=0, latched opcode/index=0. All outputs are 0.
- Reset mid-EXEC aborts the op with no `done` pulse.

## Timing
- Request to grant
  - A `req` present at edge k gives `gnt`/`dec_enable` high from edge k to edge k+L.
  - `done` is high from edge k+L to edge k+L+1.
  - `busy` is high for L+1 cycles.
- Issue period: L+2 cycles per op (IDLE, L×EXEC, DONE). Back-to-back throughput is one op every L+2 cycles.
- `MULTI_LAT`=1 makes every op 1 cycle long; `MULTI_MASK` then has no effect.
- `cnt` is 4 bits. `MULTI_LAT`=16 loads 15 and must not wrap.
- Reset deassertion is not synchronized inside the block. The first grant after release goes to the lowest asserted index from 0.

## Test plan
- Single short op: `req`=0001, op0=5'd3.
  - Expect `gnt`=0001, `dec_enable`=1, `dec_opcode`=3 for exactly 1 cycle.
  - Then `done`=0001 for 1 cycle, then IDLE with all outputs 0.
- Multi-cycle op: `req`=0100, op2=5'd20, `MULTI_LAT`=4.
  - Expect `dec_enable`/`gnt`=0100 for 4 cycles, `dec_opcode`=20 throughout, then `done`=0100.
  - Repeat with op=15 (1 cycle), 16 (4 cycles) and 31 (4 cycles).
- Round-robin: all four requesters assert; each drops and re-raises one cycle after its `done`.
  - Expect grant order 0,1,2,3,0,1 with no repeats.
- Request subset: `req`=1010 after a grant to 1.
  - Expect the next grant to 3, then 1.
- Opcode change and `req` drop during EXEC: op1=5'd18 granted, opcode changed to 5'd2 and `req` dropped on EXEC cycle 2.
  - Expect `dec_opcode` to stay 18 for 4 cycles and `done`=0010 to still pulse.
- Reset mid-EXEC: pull `rst_n` low in EXEC cycle 2 of a 4-cycle op granted to requester 2.
  - Expect all outputs 0 immediately with no `done`.
  - After release with `req`=1111, expect the first grant to 0.
